// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encodings and BCD constants for the oven timer controller.
package microwave_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    LOAD    = 3'd2,
    RUNNING = 3'd3,
    PAUSED  = 3'd4,
    DONE    = 3'd5
  } state_e;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ST_MAX = 4'd5;
  // A key is usable only if it is a BCD digit and the current units digit can legally become seconds-tens.
  function automatic logic key_ok(logic [BCD_W-1:0] d, logic [BCD_W-1:0] so);
    return (d <= 4'd9) && (so <= ST_MAX);
  endfunction
endpackage

// File: rtl/microwave_timer_ctrl_tick_prescaler.sv
// tick_prescaler: modulo-N counter with sync clear, hold and terminal-count flag.
module tick_prescaler #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign term_o = cnt_q == W'(N - 1);
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : term_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad preset entry, countdown sequencing and magnetron control for the MM:SS timer.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DONE_CYCLES = 150_000_000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [11:0] t_data,
  output logic        t_load,
  output logic        t_enable,
  output logic        t_clearn,
  output logic        mag_on,
  output logic        done_led,
  output logic [2:0]  state_o
);
  state_e state_q, state_d;
  logic [11:0] preset_q, preset_d;
  logic load_q, clearn_q, mag_q, done_q;
  logic run_cnt, tick_term, done_term;
  // The prescaler only advances on cycles that stay in RUNNING, so a pause never swallows a tick.
  assign run_cnt = (state_q == RUNNING) && door_closed && !stop_btn && !timer_zero;
  tick_prescaler #(.N(TICK_DIV)) u_tick (
    .clk(clk), .rst(clear), .clr_i(state_q == LOAD), .en_i(run_cnt), .term_o(tick_term)
  );
  tick_prescaler #(.N(DONE_CYCLES)) u_done (
    .clk(clk), .rst(clear), .clr_i(state_q != DONE), .en_i(1'b1), .term_o(done_term)
  );
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    case (state_q)
      IDLE, ENTRY:
        if (state_q == ENTRY && stop_btn) begin
          state_d  = IDLE;
          preset_d = '0;
        end else if (state_q == ENTRY && start_btn && door_closed && preset_q != '0)
          state_d = LOAD;
        else if (key_valid && key_ok(key_digit, preset_q[3:0])) begin
          preset_d = {preset_q[7:0], key_digit};
          state_d  = ENTRY;
        end
      LOAD:    state_d = RUNNING;
      RUNNING: state_d = (!door_closed || stop_btn) ? PAUSED : timer_zero ? DONE : RUNNING;
      PAUSED:
        if (stop_btn) begin
          state_d  = IDLE;
          preset_d = '0;
        end else if (start_btn && door_closed)
          state_d = RUNNING;
      DONE:
        if (done_term || stop_btn || !door_closed) begin
          state_d  = IDLE;
          preset_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state_q  <= IDLE;
      preset_q <= '0;
      load_q   <= 1'b0;
      clearn_q <= 1'b1;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      load_q   <= state_d == LOAD;
      clearn_q <= !(state_q == PAUSED && stop_btn);
      mag_q    <= state_d == RUNNING;
      done_q   <= state_d == DONE;
    end
  assign t_data   = preset_q;
  assign t_load   = load_q;
  assign t_enable = run_cnt && tick_term;
  assign t_clearn = clearn_q;
  assign mag_on   = mag_q && door_closed;
  assign done_led = done_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: scenario tasks plus randomized cooks against a seconds-based timer and digit-list preset model.
module tb_microwave_timer_ctrl;
  localparam int TD = 4;
  localparam int DC = 8;
  logic clk = 1'b0, clear = 1'b1, key_valid = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, door_closed = 1'b1;
  logic [3:0] key_digit = 4'd0;
  logic timer_zero;
  logic [11:0] t_data;
  logic t_load, t_enable, t_clearn, mag_on, done_led;
  logic [2:0] state_o;
  int checks = 0, failures = 0;
  int tm_secs = 0;
  int pq[3] = '{0, 0, 0};
  bit entered = 0;

  microwave_timer_ctrl #(.TICK_DIV(TD), .DONE_CYCLES(DC)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
    .start_btn(start_btn), .stop_btn(stop_btn), .door_closed(door_closed), .timer_zero(timer_zero),
    .t_data(t_data), .t_load(t_load), .t_enable(t_enable), .t_clearn(t_clearn),
    .mag_on(mag_on), .done_led(done_led), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural timer: holds remaining time as plain seconds.
  always @(posedge clk or posedge clear)
    if (clear) tm_secs <= 0;
    else if (!t_clearn) tm_secs <= 0;
    else if (t_load) tm_secs <= int'(t_data[11:8]) * 60 + int'(t_data[7:4]) * 10 + int'(t_data[3:0]);
    else if (t_enable && tm_secs > 0) tm_secs <= tm_secs - 1;
  assign timer_zero = tm_secs == 0;

  function automatic logic [11:0] model_data();
    return 12'(pq[0] * 256 + pq[1] * 16 + pq[2]);
  endfunction

  function automatic int model_secs();
    return pq[0] * 60 + pq[1] * 10 + pq[2];
  endfunction

  task automatic model_clear();
    pq = '{0, 0, 0};
    entered = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic press_key(input int d);
    if (d <= 9 && pq[2] <= 5) begin
      pq[0] = pq[1];
      pq[1] = pq[2];
      pq[2] = d;
      entered = 1;
    end
    key_digit = 4'(d);
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    #1;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    #1;
  endtask

  task automatic run_cook(input int secs);
    int k;
    int ens;
    logic exp_en;
    k = 0;
    ens = 0;
    pulse_start();
    checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL cook_load_state: got %0d want 2", state_o); end
    checks++; if (t_load !== 1'b1) begin failures++; $display("FAIL cook_load_pulse: got %b want 1", t_load); end
    checks++; if (t_enable !== 1'b0) begin failures++; $display("FAIL cook_load_noen: got %b want 0", t_enable); end
    cyc();
    while (state_o == 3'd3 && k < TD * secs + 20) begin
      exp_en = (k % TD == TD - 1) && (k / TD < secs);
      checks++; if (t_enable !== exp_en) begin failures++; $display("FAIL cook_enable k=%0d: got %b want %b", k, t_enable, exp_en); end
      checks++; if (mag_on !== 1'b1 || t_load !== 1'b0) begin failures++; $display("FAIL cook_mag k=%0d: got mag=%b load=%b want mag=1 load=0", k, mag_on, t_load); end
      ens += int'(t_enable);
      k++;
      cyc();
    end
    checks++; if (k != TD * secs + 1) begin failures++; $display("FAIL cook_run_len: got %0d want %0d", k, TD * secs + 1); end
    checks++; if (ens != secs) begin failures++; $display("FAIL cook_decrements: got %0d want %0d", ens, secs); end
    model_clear();
    for (int i = 0; i < DC; i++) begin
      checks++; if (state_o !== 3'd5 || done_led !== 1'b1 || mag_on !== 1'b0) begin failures++; $display("FAIL cook_done i=%0d: got st=%0d led=%b mag=%b want st=5 led=1 mag=0", i, state_o, done_led, mag_on); end
      cyc();
    end
    checks++; if (state_o !== 3'd0 || done_led !== 1'b0 || t_data !== 12'h000) begin failures++; $display("FAIL cook_return: got st=%0d led=%b data=%h want st=0 led=0 data=000", state_o, done_led, t_data); end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (t_data !== 12'h000) begin failures++; $display("FAIL reset_data: got %h want 000", t_data); end
    checks++; if (t_load !== 1'b0 || t_enable !== 1'b0) begin failures++; $display("FAIL reset_strobes: got load=%b en=%b want 0 0", t_load, t_enable); end
    checks++; if (t_clearn !== 1'b1) begin failures++; $display("FAIL reset_clearn: got %b want 1", t_clearn); end
    checks++; if (mag_on !== 1'b0 || done_led !== 1'b0) begin failures++; $display("FAIL reset_mag_led: got mag=%b led=%b want 0 0", mag_on, done_led); end
    clear = 1'b0;
    cyc();
  endtask

  task automatic test_full_cook();
    model_clear();
    press_key(1);
    press_key(3);
    press_key(0);
    checks++; if (t_data !== 12'h130) begin failures++; $display("FAIL full_preset: got %h want 130", t_data); end
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL full_entry: got %0d want 1", state_o); end
    run_cook(90);
  endtask

  task automatic test_key_reject();
    press_key(7);
    press_key(2);
    checks++; if (t_data !== 12'h007) begin failures++; $display("FAIL reject_so: got %h want 007", t_data); end
    press_key(11);
    checks++; if (t_data !== 12'h007 || state_o !== 3'd1) begin failures++; $display("FAIL reject_nonbcd: got data=%h st=%0d want 007 1", t_data, state_o); end
    pulse_stop();
    model_clear();
    checks++; if (t_data !== 12'h000 || state_o !== 3'd0) begin failures++; $display("FAIL entry_stop: got data=%h st=%0d want 000 0", t_data, state_o); end
    pulse_start();
    checks++; if (t_load !== 1'b0 || state_o !== 3'd0) begin failures++; $display("FAIL start_empty: got load=%b st=%0d want 0 0", t_load, state_o); end
  endtask

  task automatic test_pause();
    press_key(5);
    checks++; if (t_data !== 12'h005) begin failures++; $display("FAIL pause_preset: got %h want 005", t_data); end
    pulse_start();
    cyc();
    cyc();
    cyc();
    door_closed = 1'b0;
    #1;
    checks++; if (mag_on !== 1'b0 || t_enable !== 1'b0) begin failures++; $display("FAIL pause_door_open: got mag=%b en=%b want 0 0", mag_on, t_enable); end
    cyc();
    checks++; if (state_o !== 3'd4 || mag_on !== 1'b0) begin failures++; $display("FAIL pause_state: got st=%0d mag=%b want 4 0", state_o, mag_on); end
    cyc();
    door_closed = 1'b1;
    cyc();
    pulse_start();
    checks++; if (state_o !== 3'd3 || t_enable !== 1'b0 || mag_on !== 1'b1) begin failures++; $display("FAIL pause_resume: got st=%0d en=%b mag=%b want 3 0 1", state_o, t_enable, mag_on); end
    cyc();
    checks++; if (t_enable !== 1'b1) begin failures++; $display("FAIL resume_tick: got %b want 1", t_enable); end
    cyc();
    cyc();
    cyc();
    cyc();
    door_closed = 1'b0;
    #1;
    checks++; if (t_enable !== 1'b0) begin failures++; $display("FAIL wrap_suppress: got %b want 0", t_enable); end
    cyc();
    door_closed = 1'b1;
    pulse_start();
    checks++; if (t_enable !== 1'b1) begin failures++; $display("FAIL wrap_resume: got %b want 1", t_enable); end
    cyc();
    checks++; if (tm_secs != 3) begin failures++; $display("FAIL pause_timer: got %0d want 3", tm_secs); end
    pulse_stop();
    checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL run_stop: got %0d want 4", state_o); end
  endtask

  task automatic test_start_stop_same();
    start_btn = 1'b1;
    stop_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    stop_btn = 1'b0;
    #1;
    model_clear();
    checks++; if (state_o !== 3'd0 || t_clearn !== 1'b0 || t_data !== 12'h000) begin failures++; $display("FAIL both_btn: got st=%0d clrn=%b data=%h want 0 0 000", state_o, t_clearn, t_data); end
    cyc();
    checks++; if (t_clearn !== 1'b1 || tm_secs != 0) begin failures++; $display("FAIL clearn_once: got clrn=%b tm=%0d want 1 0", t_clearn, tm_secs); end
  endtask

  task automatic test_async_clear();
    press_key(2);
    pulse_start();
    cyc();
    cyc();
    cyc();
    #1 clear = 1'b1;
    #1;
    model_clear();
    checks++; if (mag_on !== 1'b0 || state_o !== 3'd0) begin failures++; $display("FAIL async_clear: got mag=%b st=%0d want 0 0", mag_on, state_o); end
    checks++; if (t_data !== 12'h000 || t_load !== 1'b0 || t_enable !== 1'b0 || t_clearn !== 1'b1 || done_led !== 1'b0) begin failures++; $display("FAIL async_outputs: got data=%h load=%b en=%b clrn=%b led=%b", t_data, t_load, t_enable, t_clearn, done_led); end
    cyc();
    clear = 1'b0;
    cyc();
  endtask

  task automatic test_done_door();
    int n;
    n = 0;
    press_key(1);
    pulse_start();
    while (state_o != 3'd5 && n < 100) begin
      cyc();
      n++;
    end
    checks++; if (state_o !== 3'd5) begin failures++; $display("FAIL done_reach: got %0d want 5", state_o); end
    cyc();
    cyc();
    door_closed = 1'b0;
    #1;
    checks++; if (done_led !== 1'b1 || mag_on !== 1'b0) begin failures++; $display("FAIL done_lit: got led=%b mag=%b want 1 0", done_led, mag_on); end
    cyc();
    model_clear();
    checks++; if (state_o !== 3'd0 || done_led !== 1'b0 || t_data !== 12'h000) begin failures++; $display("FAIL done_door_exit: got st=%0d led=%b data=%h want 0 0 000", state_o, done_led, t_data); end
    door_closed = 1'b1;
    press_key(4);
    checks++; if (t_data !== 12'h004 || state_o !== 3'd1) begin failures++; $display("FAIL done_keys_again: got data=%h st=%0d want 004 1", t_data, state_o); end
  endtask

  task automatic test_random_cook();
    int n;
    int d;
    for (int it = 0; it < 4; it++) begin
      pulse_stop();
      model_clear();
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        d = $urandom_range(0, 12);
        press_key(d);
        checks++; if (t_data !== model_data()) begin failures++; $display("FAIL rand_entry it=%0d key=%0d: got %h want %h", it, d, t_data, model_data()); end
      end
      if (model_secs() == 0) begin
        pulse_start();
        checks++; if (t_load !== 1'b0 || state_o !== (entered ? 3'd1 : 3'd0)) begin failures++; $display("FAIL rand_zero_start: got load=%b st=%0d want 0 %0d", t_load, state_o, entered); end
      end else
        run_cook(model_secs());
    end
  endtask

  initial begin
    test_reset();
    test_full_cook();
    test_key_reject();
    test_pause();
    test_start_stop_same();
    test_async_clear();
    test_done_door();
    test_random_cook();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Control FSM that sequences the MM:SS countdown timer (minutes digit, seconds-tens digit mod 6, seconds-units digit mod 10) for the oven front panel.
- Collects keypad digits into a 3-digit preset.
- Loads the preset into the timer and generates the once-per-second count enable.
- Handles start, stop and door events, drives the magnetron enable, and signals completion when the timer reports zero.
- Sits between the panel inputs (already debounced and single-cycle) and the timer datapath.

Parameters:
TICK_DIV, 50_000_000, clk cycles per countdown step (1 Hz at 50 MHz); must be ≥ 2
DONE_CYCLES, 150_000_000, cycles done_led stays lit before auto-return to IDLE; must be ≥ 1

Ports:
clk  in  1  system clock, all logic on rising edge
clear  in  1  asynchronous active-high reset
key_valid  in  1  single-cycle strobe, key_digit valid
key_digit  in  4  BCD digit from keypad
start_btn  in  1  single-cycle start press
stop_btn  in  1  single-cycle stop/cancel press
door_closed  in  1  level, 1 = door shut
timer_zero  in  1  timer reports 0:00 (combinational from timer)
t_data  out  12  preset to timer {min, st, so}, BCD
t_load  out  1  one-cycle load strobe to timer
t_enable  out  1  one-cycle decrement strobe to timer
t_clearn  out  1  active-low synchronous clear to timer
mag_on  out  1  magnetron enable
done_led  out  1  cook-complete indicator
state_o  out  3  current FSM state encoding, for the display block

Behaviour:
- Reset (clear=1, async): state IDLE; preset 000; prescaler 0; done counter 0. Outputs t_data=0, t_load=0, t_enable=0, t_clearn=1, mag_on=0, done_led=0.
- States: IDLE=0, ENTRY=1, LOAD=2, RUNNING=3, PAUSED=4, DONE=5.
- Digit entry, in IDLE or ENTRY, on key_valid:
  - If key_digit > 9: ignore the key.
  - If current so > 5: ignore the key, because so would shift into the tens-of-seconds slot.
  - Otherwise shift: min<=st, st<=so, so<=key_digit, and go to ENTRY.
  - Digits shifted out of min are lost.
  - t_data reflects the preset continuously.
- ENTRY, stop_btn: preset<=000, go to IDLE.
- ENTRY, start_btn:
  - Door closed and preset ≠ 000: go to LOAD.
  - Otherwise: ignore.
- LOAD (one cycle): t_load=1, go to RUNNING. The prescaler clears on entry to RUNNING.
- RUNNING:
  - mag_on=1.
  - The prescaler counts 0..TICK_DIV-1. t_enable=1 for exactly the one cycle with prescaler = TICK_DIV-1.
  - First decrement occurs TICK_DIV cycles after RUNNING is entered.
- RUNNING transitions, priority high to low:
  1. door_closed=0 → PAUSED.
  2. stop_btn → PAUSED.
  3. timer_zero=1 → DONE.
- RUNNING, same-cycle rules:
  - If door opens in the same cycle the prescaler wraps, t_enable is suppressed.
  - start_btn is ignored in RUNNING.
- PAUSED:
  - mag_on=0; prescaler holds its value.
  - start_btn with door_closed=1 → RUNNING, resuming the held prescaler; no reload.
  - stop_btn → IDLE, with t_clearn=0 for that one transition cycle and preset<=000.
  - start_btn and stop_btn in the same cycle: stop wins.
- DONE:
  - mag_on=0, done_led=1; the done counter runs.
  - Go to IDLE when the counter reaches DONE_CYCLES-1, or on stop_btn, or on door_closed falling (0 seen).
  - On exit: preset<=000; done_led is 0 from the first IDLE cycle.
- Keys received outside IDLE/ENTRY are ignored.
- Reset asserted mid-operation forces IDLE immediately and drops mag_on asynchronously.
- t_load and t_enable are never high in the same cycle.
- mag_on is high only in RUNNING, and only while door_closed=1; it is registered from the next-state logic so it has no glitch.

Decomposition:
- Shared package `microwave_pkg` holds:
  - state encodings (IDLE..DONE);
  - a BCD digit width constant of 4;
  - a seconds-tens maximum constant of 5.
- One natural sub-module: `tick_prescaler`. It is a TICK_DIV counter with clear, hold and terminal-pulse output, and is reused for the done timeout with DONE_CYCLES.

Test Plan (TICK_DIV=4, DONE_CYCLES=8, behavioural timer model attached):
1. Keys 1,3,0, then start with door closed → t_data=0x130; t_load pulses in the cycle after start; mag_on=1 the next cycle; first t_enable 4 cycles later; t_enable repeats every 4 cycles until the model reaches 0:00 → DONE, done_led=1 for 8 cycles, then IDLE.
2. Keys 7 then 2 → key 2 rejected (so=7 > 5), t_data stays 0x007. Key 11 → ignored. Start with preset 000 → no t_load, state stays IDLE.
3. Running at preset 0x005: open door 2 cycles into a tick period → PAUSED, mag_on=0 that cycle, no t_enable. Close door, press start → resume; next t_enable arrives 2 cycles later.
4. PAUSED, start_btn and stop_btn in the same cycle → IDLE, t_clearn=0 for one cycle, t_data=0x000.
5. Assert clear mid-RUNNING → mag_on=0 immediately; all outputs at reset values; state_o=0.
6. In DONE, open door on cycle 3 → IDLE immediately, done_led=0; keys accepted again.
